count_seq_ctrl: RTL and testbench
=================================

# count_seq_ctrl

Sequencing controller for the team's 8-bit enable/clear counter. It accepts a command carrying terminal value, prescale and mode, then drives the counter's clear and enable inputs. It watches the counter value, flags each terminal-count period with a done pulse, and reloads or stops as commanded. It sits between a command source (CPU register block or higher-level sequencer) and one counter instance.

## Interface
- `WIDTH`, 8: counter width; applies to cmd_limit, cnt_value and done_cnt.
- `PS_W`, 8: prescale width.
- `clk` input 1: single clock; everything is rising-edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: controller can accept a command; high only in IDLE.
- `cmd_limit` input WIDTH: terminal count value L.
- `cmd_prescale` input PS_W: prescale P; the counter advances once every P+1 cycles.
- `cmd_mode` input 1: 0 = one-shot, 1 = auto-reload.
- `abort` input 1: stop the current run.
- `cnt_clr` output 1: drives the counter's synchronous clear (counter gives clear priority over enable).
- `cnt_en` output 1: drives the counter's enable.
- `cnt_value` input WIDTH: the counter's registered output.
- `busy` output 1: high in CLEAR and RUN.
- `done` output 1: one-cycle pulse at each terminal count.
- `done_cnt` output WIDTH: number of done pulses since the last accepted command; saturates.

## Operation
- **States:** IDLE, CLEAR, RUN. The FSM has no other states.
- **IDLE**
  - cmd_ready=1; cnt_en=0; cnt_clr=0.
  - On cmd_valid&&cmd_ready, latch L, P and mode, clear done_cnt to 0, and go to CLEAR.
- **CLEAR** (exactly one cycle)
  - cnt_clr=1; cnt_en=0; prescaler ps is set to 0.
  - Next state is RUN.
- **RUN**
  - ps counts 0..P. A "tick" is a cycle where ps==P; ps returns to 0 after a tick.
  - Tick with cnt_value != L: cnt_en=1.
  - Tick with cnt_value == L: done=1 and cnt_en=0.
    - One-shot: go to IDLE. The counter holds L.
    - Auto-reload: cnt_clr=1 in the same cycle, ps restarts, and the FSM stays in RUN.
  - Non-tick cycles: cnt_en=0 and cnt_clr=0.
- **Counter drive rule:** cnt_en and cnt_clr are never both high.
- **Output decode:** cnt_en, cnt_clr, done, busy and cmd_ready decode combinationally from the state, ps, the latched L/P/mode and cnt_value. No path runs from cmd_* or abort to any output.
- **abort**
  - Sampled in CLEAR or RUN; next state is IDLE.
  - Outputs in the abort cycle are unaffected, so a coincident done still pulses and counts.
  - Ignored in IDLE. The counter keeps its value.
- **cmd_valid outside IDLE:** ignored; no queueing.
- **done_cnt:** increments the cycle after each done pulse and saturates at 2^WIDTH-1.
- **Width rule:** comparisons are exact WIDTH-bit equality. L=0 is legal: done fires on every tick.
- **Reset values** (asynchronous, while rst_n=0):
  - State IDLE, ps=0, latched L/P/mode=0, done_cnt=0.
  - Outputs: cmd_ready=1, busy=0, cnt_en=0, cnt_clr=0, done=0.
- **Reset mid-run:** returns to IDLE immediately. The counter is not cleared by the controller until the next CLEAR.

## Timing
- Command accepted at cycle T:
  - CLEAR at T+1 (cnt_clr=1).
  - RUN from T+2, with cnt_value=0 at T+2.
- First done at T+1+(L+1)(P+1).
- Auto-reload period is (L+1)(P+1) cycles, with no gap between periods.
- One-shot: IDLE and cmd_ready=1 the cycle after done. The earliest next accept is that cycle.
- abort at cycle A in CLEAR or RUN: IDLE and cmd_ready=1 at A+1; cnt_en=0 from A+1.
- Counter latency: cnt_value reflects cnt_en/cnt_clr one cycle later.

## Test plan
- Reset then L=3, P=0, mode=0 accepted at T:
  - cnt_clr at T+1; cnt_en at T+2..T+4; done at T+5 only.
  - cnt_value holds 3; cmd_ready=1 at T+6; done_cnt=1.
- L=1, P=2, mode=1:
  - done at T+7, T+13, T+19; done_cnt 1, 2, 3 on the following cycles.
  - cnt_en exactly at T+4, T+10, T+16; no cycle with both cnt_en and cnt_clr.
- L=0, P=0, mode=1:
  - done and cnt_clr high every cycle from T+2; cnt_en never high.
  - done_cnt reaches 255 and holds.
- Run L=10, P=1, mode=1; pulse cmd_valid (L=2) at T+5, then abort at T+9:
  - The second command is ignored.
  - IDLE at T+10; cnt_en=0 from T+10; no done pulse; a new command is accepted at T+10.
- Abort coincident with done (L=1, P=0, mode=1, abort at T+3):
  - done pulses at T+3; done_cnt=1; IDLE at T+4.
- rst_n low asynchronously mid-RUN:
  - All outputs go to reset values without waiting for a clock edge.
  - After release, a command runs with normal T+1 CLEAR timing.

Source files
------------

// File: rtl/count_seq_ctrl_if.sv
// Command channel between a command source and count_seq_ctrl.
// The master offers terminal value, prescale and mode; the slave answers with ready.
interface count_seq_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PS_W  = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_limit;
    logic [PS_W-1:0]  cmd_prescale;
    logic             cmd_mode;

    modport master (
        output cmd_valid,
        output cmd_limit,
        output cmd_prescale,
        output cmd_mode,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_limit,
        input  cmd_prescale,
        input  cmd_mode,
        output cmd_ready
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Sequencing controller for an 8-bit enable/clear counter: clears, prescales,
// detects terminal count, pulses done and reloads or stops as commanded.
module count_seq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PS_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    count_seq_ctrl_if.slave      cmd,
    input  logic                 abort_i,
    output logic                 cnt_clr_o,
    output logic                 cnt_en_o,
    input  logic [WIDTH-1:0]     cnt_value_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [WIDTH-1:0]     done_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [WIDTH-1:0]  lim_q, lim_d;
    logic [PS_W-1:0]   pre_q, pre_d;
    logic              mode_q, mode_d;
    logic [WIDTH-1:0]  done_cnt_q, done_cnt_d;
    logic              cmd_ready;
    logic              tick;
    logic              at_lim;

    assign tick   = (ps_q == pre_q);
    assign at_lim = (cnt_value_i == lim_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ps_q       <= '0;
            lim_q      <= '0;
            pre_q      <= '0;
            mode_q     <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ps_q       <= ps_d;
            lim_q      <= lim_d;
            pre_q      <= pre_d;
            mode_q     <= mode_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // Next state and output decode; outputs never depend on cmd_* or abort_i
    always_comb begin
        state_d    = state_q;
        ps_d       = ps_q;
        lim_d      = lim_q;
        pre_d      = pre_q;
        mode_d     = mode_q;
        done_cnt_d = done_cnt_q;
        cmd_ready  = 1'b0;
        cnt_clr_o  = 1'b0;
        cnt_en_o   = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    lim_d      = cmd.cmd_limit;
                    pre_d      = cmd.cmd_prescale;
                    mode_d     = cmd.cmd_mode;
                    done_cnt_d = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                busy_o    = 1'b1;
                cnt_clr_o = 1'b1;
                ps_d      = '0;
                state_d   = RUN;
            end
            RUN: begin
                busy_o = 1'b1;
                ps_d   = tick ? '0 : PS_W'(ps_q + PS_W'(1));
                if (tick) begin
                    if (at_lim) begin
                        done_o = 1'b1;
                        if (mode_q) cnt_clr_o = 1'b1;
                        else        state_d   = IDLE;
                    end else begin
                        cnt_en_o = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins the next state but leaves this cycle's outputs alone
        if (abort_i && (state_q == CLEAR || state_q == RUN)) state_d = IDLE;

        if (done_o && (done_cnt_q != '1)) done_cnt_d = WIDTH'(done_cnt_q + WIDTH'(1));
    end

    assign cmd.cmd_ready = cmd_ready;
    assign done_cnt_o    = done_cnt_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl driving a behavioural 8-bit clear/enable counter.
module tb_count_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       abort;
    logic       cnt_clr, cnt_en, busy, done;
    logic [7:0] cnt_value = 8'd0;
    logic [7:0] done_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    count_seq_ctrl_if #(.WIDTH(8), .PS_W(8)) cmd_if ();

    count_seq_ctrl #(.WIDTH(8), .PS_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd_if),
        .abort_i     (abort),
        .cnt_clr_o   (cnt_clr),
        .cnt_en_o    (cnt_en),
        .cnt_value_i (cnt_value),
        .busy_o      (busy),
        .done_o      (done),
        .done_cnt_o  (done_cnt)
    );

    always #5 clk = ~clk;

    // Counter being controlled: clear has priority over enable
    always @(posedge clk) begin
        if (cnt_clr)     cnt_value <= 8'd0;
        else if (cnt_en) cnt_value <= cnt_value + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a command in the current cycle T; returns in cycle T+1
    task automatic send_cmd(input logic [7:0] l, input logic [7:0] p, input logic m);
        cmd_if.cmd_valid    = 1'b1;
        cmd_if.cmd_limit    = l;
        cmd_if.cmd_prescale = p;
        cmd_if.cmd_mode     = m;
        chk("cmd_ready_at_accept", 32'(cmd_if.cmd_ready), 32'd1);
        step();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input logic e_clr, input logic e_en,
                            input logic e_done, input logic e_busy);
        chk({tag, ".clr"},  32'(cnt_clr), 32'(e_clr));
        chk({tag, ".en"},   32'(cnt_en),  32'(e_en));
        chk({tag, ".done"}, 32'(done),    32'(e_done));
        chk({tag, ".busy"}, 32'(busy),    32'(e_busy));
    endtask

    initial begin
        int unsigned dc;
        rst_n               = 1'b1;
        abort               = 1'b0;
        cmd_if.cmd_valid    = 1'b0;
        cmd_if.cmd_limit    = 8'd0;
        cmd_if.cmd_prescale = 8'd0;
        cmd_if.cmd_mode     = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.ready", 32'(cmd_if.cmd_ready), 32'd1);
        chk("reset.done_cnt", 32'(done_cnt), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // One-shot L=3 P=0
        send_cmd(8'd3, 8'd0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            chk_outs($sformatf("oneshot.k%0d", k), k == 1, k >= 2 && k <= 4, k == 5, k <= 5);
            if (k == 5) chk("oneshot.cnt_at_done", 32'(cnt_value), 32'd3);
            if (k == 6) begin
                chk("oneshot.ready", 32'(cmd_if.cmd_ready), 32'd1);
                chk("oneshot.done_cnt", 32'(done_cnt), 32'd1);
                chk("oneshot.cnt_hold", 32'(cnt_value), 32'd3);
            end
            step();
        end

        // Auto-reload L=1 P=2: done at 7,13,19; enable at 4,10,16
        send_cmd(8'd1, 8'd2, 1'b1);
        dc = 0;
        for (int k = 1; k <= 20; k++) begin
            logic e_done, e_en;
            e_done = (k == 7) || (k == 13) || (k == 19);
            e_en   = (k == 4) || (k == 10) || (k == 16);
            chk_outs($sformatf("reload.k%0d", k), (k == 1) || e_done, e_en, e_done, 1'b1);
            chk($sformatf("reload.done_cnt.k%0d", k), 32'(done_cnt), 32'(dc));
            chk("reload.en_and_clr", 32'(cnt_en & cnt_clr), 32'd0);
            if (e_done) dc++;
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("reload.abort_idle", 32'(cmd_if.cmd_ready), 32'd1);

        // L=0 P=0 reload: done every cycle, done_cnt saturates
        send_cmd(8'd0, 8'd0, 1'b1);
        chk_outs("zero.k1", 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        for (int k = 2; k <= 262; k++) begin
            chk_outs($sformatf("zero.k%0d", k), 1'b1, 1'b0, 1'b1, 1'b1);
            chk($sformatf("zero.done_cnt.k%0d", k), 32'(done_cnt), (k - 2 > 255) ? 32'd255 : 32'(k - 2));
            step();
        end
        chk("zero.saturated", 32'(done_cnt), 32'd255);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // L=10 P=1 reload, ignored command at T+5, abort at T+9
        send_cmd(8'd10, 8'd1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) begin
                cmd_if.cmd_valid = 1'b1;
                cmd_if.cmd_limit = 8'd2;
                chk("abort.ready_busy", 32'(cmd_if.cmd_ready), 32'd0);
            end
            if (k == 6) cmd_if.cmd_valid = 1'b0;
            abort = (k == 9);
            if (k < 10) begin
                chk_outs($sformatf("abort.k%0d", k), k == 1,
                         (k == 3) || (k == 5) || (k == 7) || (k == 9), 1'b0, 1'b1);
                step();
            end else begin
                chk_outs("abort.k10", 1'b0, 1'b0, 1'b0, 1'b0);
                chk("abort.ready", 32'(cmd_if.cmd_ready), 32'd1);
                chk("abort.cnt_value", 32'(cnt_value), 32'd4);
                chk("abort.done_cnt", 32'(done_cnt), 32'd0);
            end
        end

        // Abort coincident with done: L=1 P=0 reload, accepted right at abort+1
        send_cmd(8'd1, 8'd0, 1'b1);
        chk_outs("coinc.k1", 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        chk_outs("coinc.k2", 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        abort = 1'b1;
        chk_outs("coinc.k3", 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        abort = 1'b0;
        chk("coinc.ready", 32'(cmd_if.cmd_ready), 32'd1);
        chk("coinc.busy", 32'(busy), 32'd0);
        chk("coinc.done_cnt", 32'(done_cnt), 32'd1);
        chk("coinc.done_off", 32'(done), 32'd0);

        // Asynchronous reset mid-run
        send_cmd(8'd0, 8'd0, 1'b1);
        for (int k = 1; k <= 5; k++) step();
        chk("areset.pre_done_cnt", 32'(done_cnt), 32'd4);
        chk("areset.pre_done", 32'(done), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("areset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("areset.ready", 32'(cmd_if.cmd_ready), 32'd1);
        chk("areset.done_cnt", 32'(done_cnt), 32'd0);
        #1 rst_n = 1'b1;
        step();
        chk("areset.idle_after", 32'(busy), 32'd0);
        send_cmd(8'd2, 8'd0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            chk_outs($sformatf("post.k%0d", k), k == 1, k == 2 || k == 3, k == 4, k <= 4);
            if (k == 5) begin
                chk("post.ready", 32'(cmd_if.cmd_ready), 32'd1);
                chk("post.cnt_value", 32'(cnt_value), 32'd2);
                chk("post.done_cnt", 32'(done_cnt), 32'd1);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
